signed_lshift_div: RTL



---
 rtl/signed_lshift_div.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/signed_lshift_div.sv
// Sequential k-bit signed divider: restoring shift-left/subtract on magnitudes, one quotient bit per clock.
// Define SIGNED_DIV_OVF_EN to add the ovf port and saturate the -2^(k-1)/-1 quotient.
module signed_lshift_div #(
    parameter int k = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [k-1:0] dividend,
    input  logic [k-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [k-1:0] quotient,
    output logic [k-1:0] remainder,
    output logic         div_by_zero
`ifdef SIGNED_DIV_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam int CW = $clog2(k + 1);

    logic [1:0]    state_q, state_d;
    logic [k:0]    pRem_q, pRem_d;
    logic [k-1:0]  quo_q, quo_d;
    logic [k-1:0]  dMag_q, dMag_d;
    logic [CW-1:0] count_q, count_d;
    logic          dvdNeg_q, dvdNeg_d;
    logic          dvsNeg_q, dvsNeg_d;
    logic          divZero_q, divZero_d;
    logic [k-1:0]  quotient_q, quotient_d;
    logic [k-1:0]  remainder_q, remainder_d;
    logic          divByZero_q, divByZero_d;
`ifdef SIGNED_DIV_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    logic          accept;
    logic [k+1:0]  shifted;
    logic [k+1:0]  trial;
    logic [k-1:0]  quoNeg;
    logic [k-1:0]  remNeg;

    // The trial subtraction is one bit wider than P so its sign bit says whether the divisor fit.
    assign accept  = start && (state_q == IDLE || state_q == DONE);
    assign shifted = {pRem_q, quo_q[k-1]};
    assign trial   = shifted - {2'b00, dMag_q};
    assign quoNeg  = ~quo_q + k'(1);
    assign remNeg  = ~pRem_q[k-1:0] + k'(1);

    always_comb begin
        state_d     = state_q;
        pRem_d      = pRem_q;
        quo_d       = quo_q;
        dMag_d      = dMag_q;
        count_d     = count_q;
        dvdNeg_d    = dvdNeg_q;
        dvsNeg_d    = dvsNeg_q;
        divZero_d   = divZero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;
`ifdef SIGNED_DIV_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                quo_d = {quo_q[k-2:0], ~trial[k+1]};
                if (!trial[k+1]) begin
                    pRem_d = trial[k:0];
                end else begin
                    pRem_d = shifted[k:0];
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                if (divZero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvdNeg_q ? quoNeg : quo_q;
                    divByZero_d = 1'b1;
                end else begin
                    quotient_d  = (dvdNeg_q ^ dvsNeg_q) ? quoNeg : quo_q;
                    remainder_d = dvdNeg_q ? remNeg : pRem_q[k-1:0];
                    divByZero_d = 1'b0;
                end
`ifdef SIGNED_DIV_OVF_EN
                // Only -2^(k-1)/-1 yields a same-sign magnitude with the top bit set.
                ovf_d = !divZero_q && !(dvdNeg_q ^ dvsNeg_q) && quo_q[k-1];
                if (ovf_d) begin
                    quotient_d = {1'b0, {(k-1){1'b1}}};
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Magnitudes stay k-bit unsigned so -2^(k-1) maps to 2^(k-1) exactly.
        if (accept) begin
            dvdNeg_d  = dividend[k-1];
            dvsNeg_d  = divisor[k-1];
            quo_d     = dividend[k-1] ? (~dividend + k'(1)) : dividend;
            dMag_d    = divisor[k-1] ? (~divisor + k'(1)) : divisor;
            pRem_d    = '0;
            count_d   = CW'(k);
            divZero_d = (divisor == '0);
            state_d   = (divisor == '0) ? FIX : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pRem_q      <= '0;
            quo_q       <= '0;
            dMag_q      <= '0;
            count_q     <= '0;
            dvdNeg_q    <= 1'b0;
            dvsNeg_q    <= 1'b0;
            divZero_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
`ifdef SIGNED_DIV_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pRem_q      <= pRem_d;
            quo_q       <= quo_d;
            dMag_q      <= dMag_d;
            count_q     <= count_d;
            dvdNeg_q    <= dvdNeg_d;
            dvsNeg_q    <= dvsNeg_d;
            divZero_q   <= divZero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
`ifdef SIGNED_DIV_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;
`ifdef SIGNED_DIV_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule
